run_burst_gen: RTL and testbench
================================

# run_burst_gen

Serial stimulus transmitter for the consecutive-ones detector path.
- On a start request it emits a programmed burst pattern on a single serial line: `run_len` ones followed by `gap_len` zeros, repeated `reps` times.
- It also produces a cycle-aligned expected-detector output. Bench and self-test logic compare this against a downstream ≥3-consecutive-ones detector.
- It sits upstream of the detector and drives its serial input directly.

## Interface
Parameters:
- LEN_W, default 8: width of `run_len` and `gap_len`.
- REP_W, default 8: width of `reps`.

Ports (`reset` is asynchronous, active-low; clock is `clock`):
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: request a burst sequence; sampled only in IDLE.
- run_len, input, LEN_W: number of one-cycles per run; latched on accepted start.
- gap_len, input, LEN_W: number of zero-cycles after each run; latched on accepted start.
- reps, input, REP_W: number of run+gap repetitions; latched on accepted start.
- x_out, output, 1: registered serial data to the detector.
- busy, output, 1: high while a sequence is being emitted.
- done, output, 1: one-cycle pulse when a sequence completes.
- exp_y, output, 1: registered expected detector output.

## Operation
- States:
  - IDLE: x_out=0, busy=0.
  - RUN: x_out=1.
  - GAP: x_out=0.
- Registers: run counter (LEN_W), gap counter (LEN_W), repetition counter (REP_W), 2-bit saturating ones-history counter. All are loaded from the latched operands, never from live inputs.
- IDLE with start=1 accepts the request:
  - Operands are latched.
  - If reps==0, or run_len==0 and gap_len==0: stay in IDLE, pulse done next cycle, busy stays 0.
  - Else if run_len!=0: go to RUN.
  - Else: go to GAP.
- RUN: after run_len cycles go to GAP if gap_len!=0; otherwise start the next repetition or finish.
- GAP: after gap_len cycles start the next repetition (RUN, or GAP again if run_len==0) or finish.
- Finish:
  - Return to IDLE.
  - done=1 for exactly one cycle, coincident with the first IDLE cycle.
  - busy=0 in that same cycle.
- start while busy is ignored; the operand inputs are don't-care outside the accept cycle.
- gap_len==0 with reps>1 concatenates runs. x_out stays 1 across the repetition boundary with no glitch.
- exp_y models the detector:
  - exp_y=1 in cycle t+1 iff x_out was 1 in cycles t, t-1 and t-2.
  - History clears on any x_out=0 cycle and on reset.
  - The history counter saturates at 3.
- Reset in mid-sequence: return to IDLE immediately and abort the sequence with no done pulse.

## Timing
- Reset values: x_out=0, busy=0, done=0, exp_y=0, state IDLE, all counters 0.
- Latency: start accepted at edge k, so first x_out/busy change is visible after edge k+1.
- A sequence occupies exactly reps*(run_len+gap_len) busy cycles. done follows in the next cycle.
- Back-to-back: start may be asserted in the done cycle and is accepted there. The next busy period begins one cycle later.
- exp_y rises 3 cycles after the first x_out=1 cycle of a run of at least 3. It falls the cycle after the first following x_out=0.
- Runs of length 1 or 2 never assert exp_y.

## Structure
- Shared package `burst_gen_pkg` holds:
  - the state encoding IDLE/RUN/GAP;
  - the detector threshold constant (3);
  - default LEN_W/REP_W.
- One sub-module is natural: `ones_run_model`. It is the history counter plus exp_y register, reusable as a golden model for detector benches.
- The FSM and counters stay in the top module.

## Test plan
- Reset, then start with run_len=4, gap_len=2, reps=2:
  - x_out = 1111001111 00;
  - busy high for 12 cycles, done pulses once;
  - exp_y high for 2 cycles after each run.
- run_len=2, gap_len=1, reps=3: x_out=110110110; exp_y stays 0 throughout.
- run_len=3, gap_len=0, reps=2:
  - x_out high for 6 contiguous cycles;
  - exp_y high cycles 4–7 relative to the first x_out=1.
- reps=0 or run_len=gap_len=0: busy never rises; done pulses the cycle after start; x_out stays 0.
- start re-pulsed mid-sequence has no effect. Reset asserted in RUN forces x_out=0, busy=0, exp_y=0 immediately with no done pulse.
- start held high continuously with run_len=1, gap_len=1, reps=1: sequences repeat with exactly one idle/done cycle between busy periods.

Source files
------------

// File: rtl/burst_gen_pkg.sv
// Shared definitions for the burst stimulus generator: state encoding,
// detector threshold and default operand widths.
package burst_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Downstream detector fires after this many consecutive ones.
  localparam int DET_THRESH = 3;

  localparam int DEF_LEN_W = 8;
  localparam int DEF_REP_W = 8;

endpackage

// File: rtl/run_burst_gen_if.sv
// Control/stream bundle between a stimulus driver and run_burst_gen.
interface run_burst_gen_if
  import burst_gen_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W
);

  // Handshake: start is sampled only while the generator is idle; the operands
  // are captured on that same edge and ignored otherwise. busy covers every
  // emitted cycle, and done pulses once in the first idle cycle afterwards.
  logic             start;
  logic [LEN_W-1:0] run_len;
  logic [LEN_W-1:0] gap_len;
  logic [REP_W-1:0] reps;
  logic             x_out;
  logic             busy;
  logic             done;
  logic             exp_y;
  state_t           dbg_state;

  modport master (
    output start, run_len, gap_len, reps,
    input  x_out, busy, done, exp_y, dbg_state
  );

  modport slave (
    input  start, run_len, gap_len, reps,
    output x_out, busy, done, exp_y, dbg_state
  );

endinterface

// File: rtl/ones_run_model.sv
// Golden model of a >=3-consecutive-ones detector: saturating history counter
// plus registered output. Reusable wherever a detector reference is needed.
module ones_run_model
  import burst_gen_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic x_i,
  output logic exp_y_o
);

  localparam logic [1:0] HIT_LEVEL = 2'(DET_THRESH - 1);
  localparam logic [1:0] SAT_LEVEL = 2'd3;

  logic [1:0] hist_q;
  logic [1:0] hist_d;
  logic       exp_y_q;
  logic       exp_y_d;

  // hist counts ones seen before the current cycle; a zero clears it.
  always_comb begin
    hist_d  = 2'd0;
    exp_y_d = 1'b0;
    if (x_i) begin
      exp_y_d = (hist_q >= HIT_LEVEL);
      hist_d  = (hist_q == SAT_LEVEL) ? hist_q : hist_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q  <= 2'd0;
      exp_y_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      exp_y_q <= exp_y_d;
    end
  end

  assign exp_y_o = exp_y_q;

endmodule

// File: rtl/run_burst_gen.sv
// Serial burst transmitter: reps x (run_len ones, gap_len zeros) on x_out,
// with a cycle-aligned expected output of the downstream ones detector.
module run_burst_gen
  import burst_gen_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W
)
(
  input logic           clock,
  input logic           reset,
  run_burst_gen_if.slave bus
);

  state_t           state_q;
  logic [LEN_W-1:0] run_len_q;
  logic [LEN_W-1:0] gap_len_q;
  logic [REP_W-1:0] reps_q;
  logic [LEN_W-1:0] run_cnt_q;
  logic [LEN_W-1:0] gap_cnt_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic             x_out_q;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;

  logic run_last;
  logic gap_last;
  logic rep_last;
  logic degenerate;

  // Counters run upward against the latched operands.
  assign run_last   = (run_cnt_q == run_len_q - LEN_W'(1));
  assign gap_last   = (gap_cnt_q == gap_len_q - LEN_W'(1));
  assign rep_last   = (rep_cnt_q == reps_q - REP_W'(1));
  assign degenerate = (bus.reps == '0) || ((bus.run_len == '0) && (bus.gap_len == '0));

  // Outputs are registered from the current state, so they trail it by one
  // cycle; done is taken from the first IDLE cycle seeing busy_q still high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      run_len_q <= '0;
      gap_len_q <= '0;
      reps_q    <= '0;
      run_cnt_q <= '0;
      gap_cnt_q <= '0;
      rep_cnt_q <= '0;
      x_out_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          x_out_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= busy_q | zero_q;
          zero_q  <= 1'b0;
          if (bus.start) begin
            run_len_q <= bus.run_len;
            gap_len_q <= bus.gap_len;
            reps_q    <= bus.reps;
            run_cnt_q <= '0;
            gap_cnt_q <= '0;
            rep_cnt_q <= '0;
            if (degenerate) begin
              zero_q <= 1'b1;
            end else if (bus.run_len != '0) begin
              state_q <= RUN;
            end else begin
              state_q <= GAP;
            end
          end
        end

        RUN: begin
          x_out_q <= 1'b1;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          if (run_last) begin
            run_cnt_q <= '0;
            if (gap_len_q != '0) begin
              state_q <= GAP;
            end else if (rep_last) begin
              state_q <= IDLE;
            end else begin
              // gap_len==0: stay in RUN so x_out never drops between reps
              rep_cnt_q <= rep_cnt_q + REP_W'(1);
            end
          end else begin
            run_cnt_q <= run_cnt_q + LEN_W'(1);
          end
        end

        GAP: begin
          x_out_q <= 1'b0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          if (gap_last) begin
            gap_cnt_q <= '0;
            if (rep_last) begin
              state_q <= IDLE;
            end else begin
              rep_cnt_q <= rep_cnt_q + REP_W'(1);
              state_q   <= (run_len_q != '0) ? RUN : GAP;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + LEN_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          x_out_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  ones_run_model u_model (
    .clock   (clock),
    .reset   (reset),
    .x_i     (x_out_q),
    .exp_y_o (bus.exp_y)
  );

  assign bus.x_out     = x_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_run_burst_gen.sv
// Randomized and directed bench for run_burst_gen against a per-cycle
// expected-output queue built from the burst pattern rules.
module tb_run_burst_gen;
  import burst_gen_pkg::*;

  localparam int LW = DEF_LEN_W;
  localparam int RW = DEF_REP_W;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  run_burst_gen_if #(.LEN_W(LW), .REP_W(RW)) bus ();

  run_burst_gen #(.LEN_W(LW), .REP_W(RW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  // One entry per future clock edge: {x_out, busy, done} visible after it.
  logic [2:0] exp_q[$];
  logic [2:0] x_hist;
  int checks = 0;
  int errors = 0;
  int obs_busy;
  int obs_done;
  int obs_y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    x_hist = 3'b000;
  endtask

  // Expand an accepted request into its full output stream.
  task automatic model_accept(input int rl, input int gl, input int rp);
    if (rp == 0 || (rl == 0 && gl == 0)) begin
      exp_q.push_back(3'b001);
    end else begin
      for (int r = 0; r < rp; r++) begin
        for (int i = 0; i < rl; i++) exp_q.push_back(3'b110);
        for (int i = 0; i < gl; i++) exp_q.push_back(3'b010);
      end
      exp_q.push_back(3'b001);
    end
  endtask

  // ---------------- driver ----------------
  // Advance one clock edge, update the model from the sampled inputs and
  // compare all outputs 1 time unit after the edge.
  task automatic step();
    logic [2:0] cur;
    logic       ey;
    @(posedge clock);
    cur = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
    if (exp_q.size() == 0 && bus.start)
      model_accept(int'(bus.run_len), int'(bus.gap_len), int'(bus.reps));
    ey     = &x_hist;
    x_hist = {x_hist[1:0], cur[2]};
    #1;
    check("x_out", bus.x_out, cur[2]);
    check("busy",  bus.busy,  cur[1]);
    check("done",  bus.done,  cur[0]);
    check("exp_y", bus.exp_y, ey);
    obs_busy += int'(bus.busy);
    obs_done += int'(bus.done);
    obs_y    += int'(bus.exp_y);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 4000) begin
      step();
      guard++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Issue one request; poke_at>=0 re-pulses start that many cycles in.
  task automatic run_seq(input int rl, input int gl, input int rp,
                         input int poke_at, input int exp_y_cnt);
    int n;
    int guard;
    obs_busy    = 0;
    obs_done    = 0;
    obs_y       = 0;
    bus.run_len = LW'(rl);
    bus.gap_len = LW'(gl);
    bus.reps    = RW'(rp);
    bus.start   = 1'b1;
    step();
    n     = 0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 4000) begin
      bus.start   = (n == poke_at);
      bus.run_len = LW'($urandom());
      bus.gap_len = LW'($urandom());
      bus.reps    = RW'($urandom());
      step();
      n++;
      guard++;
    end
    bus.start = 1'b0;
    check("seq_drain", exp_q.size(), 0);
    check("busy_cnt", obs_busy, (rp == 0 || (rl == 0 && gl == 0)) ? 0 : rp * (rl + gl));
    check("done_cnt", obs_done, 1);
    if (exp_y_cnt >= 0) check("exp_y_cnt", obs_y, exp_y_cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start   = 1'b0;
    bus.run_len = '0;
    bus.gap_len = '0;
    bus.reps    = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check("rst_x_out", bus.x_out, 0);
    check("rst_busy",  bus.busy,  0);
    check("rst_done",  bus.done,  0);
    check("rst_exp_y", bus.exp_y, 0);
    check("rst_state", bus.dbg_state, IDLE);
    reset = 1'b1;

    run_seq(4, 2, 2, -1, 4);
    run_seq(2, 1, 3, -1, 0);
    run_seq(3, 0, 2, -1, 4);
    run_seq(5, 3, 0, -1, 0);
    run_seq(0, 0, 3, -1, 0);
    run_seq(0, 3, 2, -1, 0);
    run_seq(1, 0, 4, -1, 2);
    run_seq(5, 2, 2, 3, -1);

    // start held high: one idle/done cycle between busy periods
    bus.run_len = LW'(1);
    bus.gap_len = LW'(1);
    bus.reps    = RW'(1);
    bus.start   = 1'b1;
    obs_done    = 0;
    repeat (12) step();
    bus.start = 1'b0;
    check("held_done_cnt", obs_done, 3);
    drain("held_drain");

    // reset asserted while in RUN
    bus.run_len = LW'(6);
    bus.gap_len = LW'(1);
    bus.reps    = RW'(2);
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    #2 reset = 1'b0;
    #1;
    check("midrst_x_out", bus.x_out, 0);
    check("midrst_busy",  bus.busy,  0);
    check("midrst_exp_y", bus.exp_y, 0);
    model_clear();
    @(posedge clock);
    #1;
    check("midrst_done", bus.done, 0);
    reset = 1'b1;
    repeat (4) step();

    for (int k = 0; k < 30; k++) begin
      run_seq($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3), -1, -1);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
